// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss.cc BCD stopwatch with run/pause/clear control and registered digit outputs.
// Define STOPWATCH_LAP_EN to add the lap (display freeze) feature; otherwise the lap input is ignored.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic [3:0] hex3,
    output logic [3:0] hex4,
    output logic [3:0] hex5,
    output logic       running,
    output logic       wrap
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [23:0]    CNT_MAX   = 24'h595999;

    logic [1:0]    r_state;
    logic [1:0]    w_stateNext;
    logic [PW-1:0] r_presc;
    logic [23:0]   r_cnt;
    logic [23:0]   w_cntInc;
    logic [23:0]   w_cntNext;
    logic [23:0]   w_disp;
    logic          r_running;
    logic          r_wrap;
    logic          w_inRun;
    logic          w_clearAcc;
    logic          w_tick;
    logic          w_atMax;

    function automatic logic [3:0] digitLimit(input int idx);
        return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
    endfunction

    assign w_inRun    = (r_state == S_RUN);
    assign w_clearAcc = ~w_inRun & clear;
    // A start_stop that pauses the run also swallows a coincident tick; the prescaler holds instead.
    assign w_tick     = w_inRun & ~start_stop & (r_presc == PRESC_MAX);
    assign w_atMax    = (r_cnt == CNT_MAX);

    always_comb begin
        w_stateNext = r_state;
        if (w_clearAcc) begin
            w_stateNext = S_IDLE;
        end else if (start_stop) begin
            w_stateNext = w_inRun ? S_PAUSE : S_RUN;
        end
    end

    always_comb begin
        logic carry;
        carry    = 1'b1;
        w_cntInc = r_cnt;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (r_cnt[i*4 +: 4] >= digitLimit(i)) begin
                    w_cntInc[i*4 +: 4] = 4'd0;
                end else begin
                    w_cntInc[i*4 +: 4] = r_cnt[i*4 +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_cntNext = r_cnt;
        if (w_clearAcc) begin
            w_cntNext = '0;
        end else if (w_tick) begin
            w_cntNext = w_cntInc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_running <= (w_stateNext == S_RUN);
            r_wrap    <= w_tick & w_atMax;
            r_cnt     <= w_cntNext;
            if (w_clearAcc) begin
                r_presc <= '0;
            end else if (w_inRun && !start_stop) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        r_frozen;
    logic        w_frozenNext;
    logic [23:0] r_disp;

    always_comb begin
        w_frozenNext = r_frozen;
        if (w_clearAcc) begin
            w_frozenNext = 1'b0;
        end else if (lap && r_state != S_IDLE) begin
            w_frozenNext = ~r_frozen;
        end
    end

    // The display register tracks the counter one-for-one unless a freeze is in force.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frozen <= 1'b0;
            r_disp   <= '0;
        end else begin
            r_frozen <= w_frozenNext;
            if (!w_frozenNext) begin
                r_disp <= w_cntNext;
            end
        end
    end

    assign w_disp = r_disp;
`else
    logic w_unused;
    assign w_unused = lap;
    assign w_disp   = r_cnt;
`endif

    assign hex0    = w_disp[3:0];
    assign hex1    = w_disp[7:4];
    assign hex2    = w_disp[11:8];
    assign hex3    = w_disp[15:12];
    assign hex4    = w_disp[19:16];
    assign hex5    = w_disp[23:20];
    assign running = r_running;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of stopwatch_ctrl with TICK_DIV=4 (a tick every 4 RUN cycles).
// Expected digits are written as packed {hex5..hex0}; the lap section runs only with STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       running;
    logic       wrap;

    int total = 0;
    int bad = 0;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .running    (running),
        .wrap       (wrap)
    );

    initial forever #5 clk = ~clk;

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Inputs are held for exactly one rising edge, then dropped; returns 1 time unit after that edge.
    task automatic applyStimulus(input logic ss, input logic clr, input logic lp);
        start_stop = ss;
        clear      = clr;
        lap        = lp;
        waitCycles(1);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] expDig,
                               input logic expRun, input logic expWrap);
        logic [25:0] obs;
        logic [25:0] exp;
        obs = {hex5, hex4, hex3, hex2, hex1, hex0, running, wrap};
        exp = {expDig, expRun, expWrap};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        waitCycles(2);
        checkOutput("reset", 24'h000000, 1'b0, 1'b0);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("idle", 24'h000000, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start", 24'h000000, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("pre_tick", 24'h000000, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("first_tick", 24'h000001, 1'b1, 1'b0);
        waitCycles(36);
        checkOutput("run40", 24'h000010, 1'b1, 1'b0);

        // Pause with the prescaler at 2, so two more RUN cycles are owed after resume.
        waitCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pause", 24'h000010, 1'b0, 1'b0);
        waitCycles(20);
        checkOutput("paused20", 24'h000010, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resume", 24'h000010, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("resume1", 24'h000010, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("resume2", 24'h000011, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("clear_run", 24'h000011, 1'b1, 1'b0);

        // Jump the count to 59:59.98 across a non-tick edge instead of running 359998 ticks.
        force dut.r_cnt = 24'h595998;
        waitCycles(1);
        release dut.r_cnt;
        checkOutput("preload", 24'h595998, 1'b1, 1'b0);
        waitCycles(2);
        checkOutput("pre_wrap", 24'h595999, 1'b1, 1'b0);
        waitCycles(4);
        checkOutput("rollover", 24'h000000, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("wrap_clear", 24'h000000, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("after_wrap", 24'h000001, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pause2", 24'h000001, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("clear_ss_pause", 24'h000000, 1'b0, 1'b0);
        waitCycles(10);
        checkOutput("idle_hold", 24'h000000, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("restart", 24'h000001, 1'b1, 1'b0);
        waitCycles(5);
        rst_n = 1'b0;
        #2;
        checkOutput("async_reset", 24'h000000, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("post_reset", 24'h000001, 1'b1, 1'b0);

`ifdef STOPWATCH_LAP_EN
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(20);
        checkOutput("lap_pre", 24'h000005, 1'b1, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lap_frozen", 24'h000005, 1'b1, 1'b0);
        waitCycles(38);
        checkOutput("lap_hold", 24'h000005, 1'b1, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lap_release", 24'h000015, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, meaning clk cycles per 10 ms count tick (100 MHz clk); legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start_stop  input  1  single-cycle pulse, toggles run/pause.
REQ-005 SHALL have port clear  input  1  single-cycle pulse, zeroes time when not running.
REQ-006 SHALL have port lap  input  1  single-cycle pulse, toggles display freeze (LAP_EN only).
REQ-007 SHALL have ports hex0..hex5  output  4 each  BCD digits for the 6-digit display driver; hex1:hex0 centiseconds, hex3:hex2 seconds, hex5:hex4 minutes.
REQ-008 SHALL have port running  output  1  high while state RUN.
REQ-009 SHALL have port wrap  output  1  one-cycle pulse on 59:59.99 -> 00:00.00 rollover.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, PAUSE; IDLE on reset.
REQ-011 SHALL transition IDLE->RUN and PAUSE->RUN on start_stop, RUN->PAUSE on start_stop.
REQ-012 SHALL, on clear in IDLE or PAUSE, zero all digits and prescaler and enter IDLE; clear in RUN SHALL be ignored.
REQ-013 SHALL give clear priority over start_stop when both are high in the same cycle in IDLE/PAUSE (result: IDLE, zeroed); in RUN, start_stop acts and clear is ignored.
REQ-014 SHALL run prescaler 0..TICK_DIV-1 only in RUN; hold its value in PAUSE (no tick loss on resume); reset to 0 on IDLE entry.
REQ-015 SHALL generate tick in the cycle prescaler equals TICK_DIV-1 while in RUN; tick SHALL be suppressed in the cycle a start_stop causes RUN->PAUSE.
REQ-016 SHALL increment time on the tick clock edge; new digits visible on outputs the cycle after the tick cycle (1-cycle latency).
REQ-017 SHALL count BCD: hex0 0-9, hex1 0-9, hex2 0-9, hex3 0-5, hex4 0-9, hex5 0-5, each carrying into the next on wrap.
REQ-018 SHALL roll 59:59.99 -> 00:00.00 on tick, stay in RUN, and assert wrap for exactly one cycle aligned with the rolled-over digits.
REQ-019 SHALL drive all outputs from registers; no combinational path from inputs to outputs.
REQ-020 SHALL never present a non-BCD value (>9, or >5 on hex3/hex5) on any digit.

Reset
REQ-021 SHALL, on rst_n low, immediately force state IDLE, prescaler 0, digits 0, lap freeze off, running 0, wrap 0, regardless of clk.
REQ-022 SHALL, on reset mid-RUN, discard the count; first start_stop after release starts from 00:00.00.

Configuration
REQ-023 SHALL honour macro STOPWATCH_LAP_EN: defined -> lap toggles freeze; while frozen, hex0..hex5 hold the value captured on the lap edge (visible next cycle) while counting continues internally; second lap resumes live digits next cycle.
REQ-024 SHALL, with STOPWATCH_LAP_EN defined, release freeze on clear (accepted) and on reset; lap in IDLE SHALL be ignored.
REQ-025 SHALL, without STOPWATCH_LAP_EN, ignore lap entirely (port present, no freeze logic), hex outputs always live.

Verification (TICK_DIV=4)
REQ-026 SHALL cover: reset, start_stop pulse, run 40 cycles -> running=1, digits 00:00.10 (hex1=1, hex0=0), first change 4 cycles after start.
REQ-027 SHALL cover: run, start_stop at prescaler=2, wait 20 cycles, start_stop -> digits frozen during PAUSE, next increment 2 cycles after resume.
REQ-028 SHALL cover: preload path by running 359999 ticks -> 59:59.99, next tick -> 00:00.00 with wrap high exactly one cycle, running stays 1.
REQ-029 SHALL cover: clear during RUN -> no effect; clear+start_stop same cycle in PAUSE -> IDLE, all hex=0, running=0.
REQ-030 SHALL cover: rst_n pulsed low between clk edges mid-RUN -> outputs 0 before next edge; then start_stop counts from 00:00.00.
REQ-031 SHALL cover (LAP_EN): lap at 00:00.05 -> outputs hold 05 for 40 cycles; second lap -> outputs show 00:00.15.
